// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/halfword/word loads and stores onto a word-wide data memory,
// with read-modify-write for sub-word stores and fault detection before any memory access.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        rsp_done,
    output logic        fault,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD_RSP, RMW_WR, STORE_RSP, ERR} state_t;

    state_t      state, state_n;
    logic [31:0] addr_q, rdata_q, merge_q, load_data, merged;
    logic [15:0] wdata_q, lane_h;
    logic [7:0]  lane_b;
    logic [2:0]  funct3_q;
    logic        we_q, accept, bad, legal, misaligned, out_of_range, is_sw;

    assign accept       = state == IDLE && req_valid;
    assign is_sw        = req_funct3 == 3'b010;
    assign legal        = req_we ? req_funct3 inside {3'b000, 3'b001, 3'b010}
                                 : req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
    assign bad          = !legal || misaligned || out_of_range;

    assign lane_b = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    assign lane_h = mem_rdata[{req_addr[1], 4'b0000} +: 16];

    always_comb begin
        load_data = req_funct3 == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
                    req_funct3 == 3'b100 ? {24'b0, lane_b} :
                    req_funct3 == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
                    req_funct3 == 3'b101 ? {16'b0, lane_h} : mem_rdata;
        merged = merge_q;
        if (funct3_q == 3'b000)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        state_n = accept ? (bad ? ERR : !req_we ? LOAD_RSP : is_sw ? STORE_RSP : RMW_WR) :
                  state == RMW_WR ? STORE_RSP : IDLE;
    end

    // Reset masks every strobe so an interrupted RMW can never write.
    assign mem_read  = !rst && accept && !bad && (!req_we || !is_sw);
    assign mem_write = !rst && ((accept && !bad && req_we && is_sw) || state == RMW_WR);
    assign mem_addr  = accept ? {2'b00, req_addr[31:2]} :
                       state == RMW_WR ? {2'b00, addr_q[31:2]} : 32'b0;
    assign mem_wdata = !mem_write ? 32'b0 : state == RMW_WR ? merged : req_wdata;
    assign rsp_done  = !rst && state inside {LOAD_RSP, STORE_RSP, ERR};
    assign fault     = !rst && state == ERR;
    assign rsp_rdata = state == LOAD_RSP && !we_q ? rdata_q : 32'b0;
    assign stall     = req_valid & ~rsp_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                we_q     <= req_we;
                wdata_q  <= req_wdata[15:0];
                if (!bad && !req_we)
                    rdata_q <= load_data;
                if (!bad && req_we && !is_sw)
                    merge_q <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed accesses checked every cycle against a byte-level memory model.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1, mem_clr = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        rsp_done, fault, stall, mem_read, mem_write;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int          checks = 0, errors = 0;
    logic        act = 1'b0, bad_e, got_fault;
    int          k, lat_e, rdn_e, wrn_e, rd_n, wr_n, done_k;
    logic [31:0] rd_e, wa_e, got;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_rdata(rsp_rdata), .rsp_done(rsp_done),
        .fault(fault), .stall(stall), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr < 64 ? mem[mem_addr[5:0]] : 32'b0;

    always @(posedge clk) begin
        if (mem_clr)
            for (int i = 0; i < 64; i++) mem[i] <= 32'b0;
        else if (mem_write && mem_addr < 64)
            mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Expected outcome of one access from the RV32I rules, applied to the reference memory.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz, sh;
        logic legal;
        logic [31:0] m, old, v;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        sz = 1 << f3[1:0];
        bad_e = !legal || (a % sz != 0) || (a / 4 >= 64);
        wa_e = a / 4;
        sh = 8 * (a % 4);
        m = sz >= 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
        old = bad_e ? 32'b0 : ref_mem[wa_e[5:0]];
        v = (old >> sh) & m;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~m;
        rd_e = (bad_e || we) ? 32'b0 : v;
        if (!bad_e && we) ref_mem[wa_e[5:0]] = (old & ~(m << sh)) | ((wd & m) << sh);
        lat_e = (!bad_e && we && sz < 4) ? 3 : 2;
        rdn_e = bad_e ? 0 : (!we || sz < 4) ? 1 : 0;
        wrn_e = (!bad_e && we) ? 1 : 0;
    endtask

    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic chg);
        model(we, f3, a, wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        k = 0; rd_n = 0; wr_n = 0; done_k = 0; act = 1'b1;
        for (int i = 0; i < lat_e + 4 && done_k == 0; i++) begin
            @(posedge clk); #1;
            if (chg) begin
                req_addr = 32'h20; req_wdata = ~wd; req_funct3 = 3'b000;
            end
        end
        act = 1'b0; req_valid = 1'b0;
        chk("latency", done_k, lat_e);
        chk("mem_read_count", rd_n, rdn_e);
        chk("mem_write_count", wr_n, wrn_e);
        if (we && !bad_e) chk("mem_word", mem[wa_e[5:0]], ref_mem[wa_e[5:0]]);
    endtask

    always @(negedge clk) begin
        if (!rst && act) begin
            k = k + 1;
            chk("stall", stall, k < lat_e);
            chk("rsp_done", rsp_done, k == lat_e);
            if (rsp_done) begin
                done_k = k; got = rsp_rdata; got_fault = fault;
                chk("fault", fault, bad_e);
                chk("rsp_rdata", rsp_rdata, rd_e);
            end else
                chk("fault_low", fault, 1'b0);
            if (mem_read || mem_write) chk("mem_addr", mem_addr, wa_e);
            rd_n += mem_read; wr_n += mem_write;
        end else if (!rst && !req_valid) begin
            chk("idle_strobes", {rsp_done, fault, stall, mem_read, mem_write}, 5'b0);
            chk("idle_mem_addr", mem_addr, 32'b0);
            chk("idle_mem_wdata", mem_wdata, 32'b0);
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {rsp_done, fault, mem_read, mem_write}, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rsp_rdata, 32'b0);
        @(posedge clk); #1;

        access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        chk("lw_data", got, 32'hDEAD_BEEF);
        chk("lw_latency", done_k, 2);
        repeat (2) @(posedge clk);
        #1;

        access(1'b1, 3'b000, 32'h12, 32'hFFFF_FF55, 1'b0);
        chk("sb_merge", mem[4], 32'hDE55_BEEF);
        chk("sb_latency", done_k, 3);
        access(1'b0, 3'b000, 32'h12, 32'h0, 1'b0);
        chk("lb_after_sb", got, 32'h0000_0055);

        access(1'b1, 3'b010, 32'h10, 32'h8001_F0FF, 1'b0);
        access(1'b0, 3'b000, 32'h10, 32'h0, 1'b0);
        chk("lb_sign", got, 32'hFFFF_FFFF);
        access(1'b0, 3'b100, 32'h10, 32'h0, 1'b0);
        chk("lbu_zero", got, 32'h0000_00FF);
        access(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
        chk("lh_sign", got, 32'hFFFF_8001);
        access(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
        chk("lhu_zero", got, 32'h0000_8001);
        access(1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
        access(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);

        access(1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
        chk("lw_misaligned_fault", got_fault, 1'b1);
        access(1'b1, 3'b001, 32'h13, 32'h1234, 1'b0);
        chk("sh_misaligned_fault", got_fault, 1'b1);
        access(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
        chk("illegal_fault", got_fault, 1'b1);
        access(1'b1, 3'b010, 32'h100, 32'h1, 1'b0);
        chk("range_fault", got_fault, 1'b1);
        access(1'b1, 3'b100, 32'h10, 32'h1, 1'b0);
        access(1'b0, 3'b101, 32'h11, 32'h0, 1'b0);
        chk("mem_untouched", mem[4], 32'h8001_F0FF);

        access(1'b1, 3'b001, 32'h1E, 32'h0000_CAFE, 1'b0);
        access(1'b1, 3'b001, 32'h1C, 32'h0000_1234, 1'b0);
        chk("sh_lanes", mem[7], 32'hCAFE_1234);
        access(1'b1, 3'b000, 32'h1F, 32'h0000_00AA, 1'b0);
        access(1'b0, 3'b010, 32'h1C, 32'h0, 1'b0);

        access(1'b1, 3'b010, 32'h20, 32'h1122_3344, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'hABCD;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst_write", {mem_write, mem_read, rsp_done}, 3'b0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst_done", rsp_done, 1'b0);
        chk("rmw_rst_rdata_q", dut.rdata_q, 32'b0);
        chk("rmw_rst_merge_q", dut.merge_q, 32'b0);
        chk("rmw_rst_mem", mem[8], 32'h1122_3344);
        @(posedge clk); #1;
        access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        chk("after_rst_lw", got, 32'h1122_3344);

        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        chk("req_change", got, 32'h8001_F0FF);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
